// File: rtl/mcif_read_eg_lat_fifo_ctrl.sv
// rtl/mcif_read_eg_lat_fifo_ctrl.sv - pointer/handshake controller for the MCIF read-egress latency FIFO
// Drives an external flop RAM; no bypass, so minimum write-to-read latency is one cycle.
module mcif_read_eg_lat_fifo_ctrl #(
  parameter int DW    = 512,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  output logic          credit_ret,
  output logic [AW:0]   fifo_count,
  output logic          fifo_idle
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_adr_q, wr_adr_d;
  logic [AW-1:0] rd_adr_q, rd_adr_d;
  logic [AW:0]   count_q,  count_d;
  logic          credit_q;
  logic          push, pop;

  // Ready/valid come only from registered occupancy: no pass-through when full.
  assign wr_prdy    = (count_q != FULL_CNT);
  assign rd_pvld    = (count_q != '0);
  assign push       = wr_pvld & wr_prdy;
  assign pop        = rd_pvld & rd_prdy;

  assign ram_we     = push;
  assign ram_wa     = wr_adr_q;
  assign ram_di     = wr_pd;
  assign ram_ra     = rd_adr_q;
  assign rd_pd      = ram_dout;

  assign credit_ret = credit_q;
  assign fifo_count = count_q;
  assign fifo_idle  = (count_q == '0) & ~wr_pvld;

  always_comb begin
    wr_adr_d = wr_adr_q;
    rd_adr_d = rd_adr_q;
    count_d  = count_q;
    if (push) wr_adr_d = wr_adr_q + 1'b1;
    if (pop)  rd_adr_d = rd_adr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_adr_q <= '0;
      rd_adr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
    end else begin
      wr_adr_q <= wr_adr_d;
      rd_adr_q <= rd_adr_d;
      count_q  <= count_d;
      credit_q <= pop;
    end
  end

endmodule

// File: tb/tb_mcif_read_eg_lat_fifo_ctrl.sv
// tb/tb_mcif_read_eg_lat_fifo_ctrl.sv - scoreboard bench for the read-egress latency FIFO controller
// Includes a behavioural 4x512 RAM with combinational read.
module tb_mcif_read_eg_lat_fifo_ctrl;

  localparam int DW = 512;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_pvld = 1'b0;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd = '0;
  logic          rd_pvld;
  logic          rd_prdy = 1'b0;
  logic [DW-1:0] rd_pd;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_dout;
  logic          credit_ret;
  logic [AW:0]   fifo_count;
  logic          fifo_idle;

  mcif_read_eg_lat_fifo_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_dout(ram_dout),
    .credit_ret(credit_ret), .fifo_count(fifo_count), .fifo_idle(fifo_idle)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_we) mem[ram_wa] <= ram_di;
  assign ram_dout = mem[ram_ra];

  int n_cmp = 0;
  int n_err = 0;
  int cred_seen = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference occupancy model and expected-data scoreboard
  logic [AW:0]   m_cnt = '0;
  logic [AW-1:0] m_wa = '0, m_ra = '0;
  logic          m_cred = 1'b0;
  logic [DW-1:0] exp_q [$];
  wire m_push = wr_pvld && (m_cnt != 3'd4);
  wire m_pop  = rd_prdy && (m_cnt != 3'd0);

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= '0; m_wa <= '0; m_ra <= '0; m_cred <= 1'b0;
      exp_q.delete();
    end else begin
      if (m_push) begin exp_q.push_back(wr_pd); m_wa <= m_wa + 1'b1; end
      if (m_pop) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_ra <= m_ra + 1'b1;
      end
      m_cnt  <= m_cnt + (m_push ? 3'd1 : 3'd0) - (m_pop ? 3'd1 : 3'd0);
      m_cred <= m_pop;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_wr_prdy", DW'(wr_prdy), DW'(m_cnt != 3'd4));
      chk("mon_rd_pvld", DW'(rd_pvld), DW'(m_cnt != 3'd0));
      chk("mon_count", DW'(fifo_count), DW'(m_cnt));
      chk("mon_idle", DW'(fifo_idle), DW'(m_cnt == 3'd0 && !wr_pvld));
      chk("mon_credit", DW'(credit_ret), DW'(m_cred));
      chk("mon_ram_we", DW'(ram_we), DW'(m_push));
      chk("mon_ram_wa", DW'(ram_wa), DW'(m_wa));
      chk("mon_ram_ra", DW'(ram_ra), DW'(m_ra));
      if (m_pop) begin
        if (exp_q.size() == 0) chk("mon_pop_unexpected", DW'(1), DW'(0));
        else chk("mon_rd_pd", rd_pd, exp_q[0]);
      end
      if (credit_ret) cred_seen++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0;
    cyc();
    reset = 1'b0;
    settle();
    chk("rst_rd_pvld", DW'(rd_pvld), DW'(0));
    chk("rst_wr_prdy", DW'(wr_prdy), DW'(1));
    chk("rst_count", DW'(fifo_count), DW'(0));
    chk("rst_credit", DW'(credit_ret), DW'(0));
  endtask

  task automatic drain(input int n);
    wr_pvld = 1'b0; rd_prdy = 1'b1;
    cyc(n);
    rd_prdy = 1'b0;
    settle();
    chk("drain_empty", DW'(rd_pvld), DW'(0));
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] w);
    logic [DW-1:0] v;
    v = {16{w}};
    return v;
  endfunction

  logic [DW-1:0] held;

  initial begin
    cyc(2);
    mon_en = 1'b1;
    do_reset();

    // 1: single push then pop
    wr_pd = {8'hA0, 504'h0}; wr_pvld = 1'b1;
    cyc();
    wr_pvld = 1'b0; settle();
    chk("t1_rd_pvld", DW'(rd_pvld), DW'(1));
    chk("t1_rd_pd", rd_pd, {8'hA0, 504'h0});
    chk("t1_count", DW'(fifo_count), DW'(1));
    rd_prdy = 1'b1;
    cyc();
    rd_prdy = 1'b0; settle();
    chk("t1_credit", DW'(credit_ret), DW'(1));
    chk("t1_rd_pvld0", DW'(rd_pvld), DW'(0));
    chk("t1_idle", DW'(fifo_idle), DW'(1));
    cyc(); settle();
    chk("t1_credit_drop", DW'(credit_ret), DW'(0));

    // 2: fill to full, ram_wa 0..3, fifth word held off
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_pd = pat(32'hD000_0000 + i); wr_pvld = 1'b1; settle();
      chk("t2_ram_wa", DW'(ram_wa), DW'(i));
      chk("t2_ram_we", DW'(ram_we), DW'(1));
      cyc();
    end
    wr_pd = pat(32'hD000_0004); settle();
    chk("t2_full_prdy", DW'(wr_prdy), DW'(0));
    chk("t2_full_count", DW'(fifo_count), DW'(4));
    chk("t2_held_no_we", DW'(ram_we), DW'(0));
    cyc(); settle();
    chk("t2_held_no_we2", DW'(ram_we), DW'(0));

    // 3: pop while full does not admit a push; write wraps to 0 next cycle
    rd_prdy = 1'b1; settle();
    chk("t3_no_push", DW'(ram_we), DW'(0));
    chk("t3_pop_d0", rd_pd, pat(32'hD000_0000));
    cyc();
    rd_prdy = 1'b0; settle();
    chk("t3_prdy_back", DW'(wr_prdy), DW'(1));
    chk("t3_wrap_wa", DW'(ram_wa), DW'(0));
    chk("t3_we", DW'(ram_we), DW'(1));
    cyc();
    drain(4);
    chk("t3_idle", DW'(fifo_idle), DW'(1));

    // 4: 2-deep prefill then 20 cycles of streaming
    do_reset();
    for (int i = 0; i < 2; i++) begin
      wr_pd = pat(32'h5000_0000 + i); wr_pvld = 1'b1; cyc();
    end
    cred_seen = 0;
    rd_prdy = 1'b1;
    for (int i = 2; i < 22; i++) begin
      wr_pd = pat(32'h5000_0000 + i); cyc();
    end
    wr_pvld = 1'b0; rd_prdy = 1'b0; settle();
    chk("t4_count", DW'(fifo_count), DW'(2));
    cyc(2);
    chk("t4_credits", DW'(cred_seen), DW'(20));
    drain(2);

    // 5: reset with three entries discards them
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_pd = pat(32'h3000_0000 + i); wr_pvld = 1'b1; cyc();
    end
    wr_pvld = 1'b0; settle();
    chk("t5_count3", DW'(fifo_count), DW'(3));
    do_reset();
    wr_pd = {64{8'h55}}; wr_pvld = 1'b1; settle();
    chk("t5_wa0", DW'(ram_wa), DW'(0));
    chk("t5_ra0", DW'(ram_ra), DW'(0));
    cyc();
    wr_pvld = 1'b0; settle();
    chk("t5_first", rd_pd, {64{8'h55}});
    drain(1);

    // 6: rd_pd stable under backpressure while pushes continue
    wr_pd = pat(32'h6000_0000); wr_pvld = 1'b1; cyc();
    for (int i = 1; i <= 5; i++) begin
      wr_pd = pat(32'h6000_0000 + i); settle();
      chk("t6_stable", rd_pd, pat(32'h6000_0000));
      cyc();
    end
    drain(5);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
